// File: rtl/trig_emulator.sv
// Programmable trigger/spill emulator feeding the front-end trigemu input.
// Generates pulse trains grouped into spills, each closed by a long cycle gate, plus CPU single pulses.
module trig_emulator #(
    parameter int USCLK  = 160,
    parameter int PULSEW = 4,
    parameter int MINPER = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        single,
    input  logic [15:0] period,
    input  logic [15:0] ntrig,
    input  logic [7:0]  gaplen,
    output logic        trigemu,
    output logic        busy,
    output logic [15:0] spillcnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SPILL = 2'd1;
    localparam logic [1:0] ST_GATE  = 2'd2;
    localparam logic [1:0] ST_TAIL  = 2'd3;

    localparam logic [15:0] PULSEW_C = 16'(PULSEW);
    localparam logic [15:0] MINPER_C = 16'(MINPER);
    localparam logic [15:0] USCLK_C  = 16'(USCLK);

    logic [1:0]  state_r, state_s;
    logic [15:0] pcnt_r, pcnt_s;
    logic [15:0] tcnt_r, tcnt_s;
    logic [15:0] gcnt_r, gcnt_s;
    logic [15:0] scnt_r, scnt_s;
    logic [15:0] per_r, per_s;
    logic [15:0] ntrig_r, ntrig_s;
    logic [15:0] glen_r, glen_s;
    logic [15:0] spillcnt_r, spillcnt_s;
    logic [15:0] per_eff_s;
    logic [7:0]  gap_eff_s;
    logic [15:0] glen_eff_s;
    logic        go_spill_s;
    logic        trig_s;
    logic        busy_s;

    // Effective configuration values that get captured whenever a spill starts
    always_comb begin
        per_eff_s  = (period < MINPER_C) ? MINPER_C : period;
        gap_eff_s  = (gaplen < 8'd2) ? 8'd2 : gaplen;
        glen_eff_s = 16'(gap_eff_s) * USCLK_C;
    end

    // Next-state logic; counters describe the clock cycle that follows the edge
    always_comb begin
        state_s    = state_r;
        pcnt_s     = pcnt_r;
        tcnt_s     = tcnt_r;
        gcnt_s     = gcnt_r;
        scnt_s     = scnt_r;
        per_s      = per_r;
        ntrig_s    = ntrig_r;
        glen_s     = glen_r;
        spillcnt_s = spillcnt_r;
        go_spill_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (scnt_r != 16'd0) begin
                    scnt_s = scnt_r - 16'd1;
                end else if (enable) begin
                    go_spill_s = 1'b1;
                end else if (single) begin
                    scnt_s = PULSEW_C;
                end else begin
                    scnt_s = 16'd0;
                end
            end
            ST_SPILL: begin
                if (pcnt_r == per_r - 16'd1) begin
                    pcnt_s = 16'd0;
                    if (!enable) begin
                        state_s = ST_IDLE;
                        tcnt_s  = 16'd0;
                    end else if ((ntrig_r != 16'd0) && (tcnt_r == ntrig_r)) begin
                        state_s = ST_GATE;
                        gcnt_s  = 16'd0;
                    end else if (ntrig_r != 16'd0) begin
                        tcnt_s = tcnt_r + 16'd1;
                    end else begin
                        tcnt_s = tcnt_r;
                    end
                end else begin
                    pcnt_s = pcnt_r + 16'd1;
                end
            end
            ST_GATE: begin
                if (gcnt_r == glen_r - 16'd1) begin
                    state_s    = ST_TAIL;
                    gcnt_s     = 16'd0;
                    pcnt_s     = 16'd0;
                    tcnt_s     = 16'd0;
                    spillcnt_s = spillcnt_r + 16'd1;
                end else begin
                    gcnt_s = gcnt_r + 16'd1;
                end
            end
            ST_TAIL: begin
                if (pcnt_r == per_r - 16'd1) begin
                    pcnt_s = 16'd0;
                    if (enable) begin
                        go_spill_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    pcnt_s = pcnt_r + 16'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // A new spill always relatches the configuration and counts its first pulse
        if (go_spill_s) begin
            state_s = ST_SPILL;
            pcnt_s  = 16'd0;
            per_s   = per_eff_s;
            ntrig_s = ntrig;
            glen_s  = glen_eff_s;
            tcnt_s  = (ntrig != 16'd0) ? 16'd1 : 16'd0;
        end else begin
            go_spill_s = 1'b0;
        end
    end

    // Output levels derived from the next state so the registers line up with it
    always_comb begin
        trig_s = ((state_s == ST_SPILL) && (pcnt_s < PULSEW_C)) ||
                 (state_s == ST_GATE) ||
                 ((state_s == ST_IDLE) && (scnt_s != 16'd0));
        busy_s = (state_s != ST_IDLE) || (scnt_s != 16'd0);
    end

    // State, counter and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            pcnt_r     <= 16'd0;
            tcnt_r     <= 16'd0;
            gcnt_r     <= 16'd0;
            scnt_r     <= 16'd0;
            per_r      <= 16'd0;
            ntrig_r    <= 16'd0;
            glen_r     <= 16'd0;
            spillcnt_r <= 16'd0;
            trigemu    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_r    <= state_s;
            pcnt_r     <= pcnt_s;
            tcnt_r     <= tcnt_s;
            gcnt_r     <= gcnt_s;
            scnt_r     <= scnt_s;
            per_r      <= per_s;
            ntrig_r    <= ntrig_s;
            glen_r     <= glen_s;
            spillcnt_r <= spillcnt_s;
            trigemu    <= trig_s;
            busy       <= busy_s;
        end
    end

    assign spillcnt = spillcnt_r;

endmodule
